dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory target answering load/store requests from the CPU datapath over a valid/ready request and response handshake.
- Replaces the zero-latency data memory, so a future multi-cycle or pipelined core can stall on memory.
- One outstanding transaction; word-organised storage with byte strobes; fixed, parameterised response latency.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; index = (req_addr - BASE_ADDR) >> 2.
- LATENCY, 2, cycles from request acceptance to first resp_valid; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, little-endian byte lanes
- req_wstrb  input  4  byte enables for store; ignored on load
- resp_valid  output  1  response present
- resp_ready  input  1  requester accepts response this cycle
- resp_rdata  output  32  load data; 0 for stores and errored accesses
- resp_err  output  1  access fault flag, valid with resp_valid

Behaviour:
- Reset: state IDLE, req_ready=1 in the cycle after rst deasserts, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0, all memory words cleared to 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready the request is accepted. Go to RESP if LATENCY==1, else go to WAIT with counter=LATENCY-1.
- WAIT: req_ready=0. Counter decrements each cycle. When counter reaches 1, go to RESP on the next edge.
- Timing: accept edge at cycle N gives resp_valid=1 from cycle N+LATENCY.
- RESP: resp_valid=1, req_ready=0. Hold resp_rdata and resp_err stable until resp_valid&&resp_ready, then go to IDLE.
- No request can be accepted in the same cycle a response completes. Minimum back-to-back spacing is LATENCY+1 cycles.
- Store commit: the write lands on the accept edge, per byte lane i where req_wstrb[i]=1. wstrb=0 is a legal no-op store and returns resp_err=0.
- Load capture: word read on the accept edge into a response register. Read-after-write is trivially ordered because only one transaction is outstanding.
- Fault (see Optional Feature): req_addr[1:0]!=0, or req_addr<BASE_ADDR, or index>=DEPTH_WORDS.
  - Faulted store writes nothing.
  - Faulted load returns rdata=0.
  - Both return resp_err=1 with normal latency.
- Request fields are sampled only at the accept edge; changes while req_ready=0 are ignored.
- Reset mid-operation (WAIT or RESP): pending response dropped, resp_valid=0 after the reset edge, memory cleared regardless of any committed store.
- resp_ready held high in IDLE/WAIT: no effect.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN.
- Defined: fault detection as above; resp_err driven.
- Undefined:
  - resp_err tied 0.
  - req_addr[1:0] ignored.
  - index = ((req_addr - BASE_ADDR) >> 2) modulo DEPTH_WORDS, so addresses wrap.
  - All accesses complete normally.

Test Plan:
- Reset then store addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF; then load addr=0x10 -> second response resp_rdata=0xDEADBEEF, resp_err=0. With LATENCY=2, resp_valid rises exactly 2 cycles after each accept.
- Preload 0x11223344 at 0x20; store wdata=0xAABBCCDD, wstrb=4'b0101 to 0x20; load 0x20 -> 0x11BB33DD.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata, resp_err stable, req_ready=0 throughout. Raise resp_ready -> req_ready=1 the following cycle.
- With DMEM_ERR_CHECK_EN:
  - Load 0x13 -> resp_err=1, rdata=0.
  - Store 0x400 (DEPTH_WORDS=256) -> resp_err=1.
  - Subsequent load of 0x0 -> 0x00000000, with memory unchanged.
- Without the macro: store 0xCAFEF00D to 0x400, then load 0x0 -> 0xCAFEF00D (wrap), resp_err=0.
- Assert rst in WAIT after a store accept -> resp_valid never asserts. A load of the same address after reset -> 0x00000000.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Multi-cycle data-memory target for the CPU datapath. It accepts one
//   load/store request at a time over a valid/ready handshake. It answers after
//   a fixed, parameterised latency over a second valid/ready handshake.
//   Storage is word-organised and stores are masked by byte strobes.
//
//   Optional feature macro: DMEM_ERR_CHECK_EN
//     defined   : misaligned, below-base and beyond-depth accesses fault.
//                 A faulted access does not write, returns rdata=0, and
//                 raises resp_err.
//     undefined : resp_err is tied 0 and address bits [1:0] are ignored.
//                 The word index wraps modulo DEPTH_WORDS.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words stored
//   LATENCY     : cycles from request accept to first resp_valid (1..15)
//   BASE_ADDR   : byte address of word 0 (4-byte aligned)
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous reset, active-high (also clears memory)
//   req_valid   : request present
//   req_ready   : responder can accept a request this cycle
//   req_write   : 1 = store, 0 = load
//   req_addr    : byte address
//   req_wdata   : store data, little-endian byte lanes
//   req_wstrb   : store byte enables (ignored on loads)
//   resp_valid  : response present
//   resp_ready  : requester accepts response this cycle
//   resp_rdata  : load data; 0 for stores and faulted accesses
//   resp_err    : access fault flag, qualified by resp_valid
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_U   = 32'(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state, state_next;
   logic [3:0]         cnt, cnt_next;
   logic [31:0]        mem [DEPTH_WORDS];
   logic [31:0]        rdata_r;
   logic [31:0]        offset;
   logic [31:0]        word_off;
   logic [IDX_W-1:0]   idx;
   logic               fault;
   logic               accept;

   assign offset   = req_addr - BASE_ADDR;
   assign word_off = offset >> 2;
   assign accept   = req_valid && req_ready;

`ifdef DMEM_ERR_CHECK_EN
   logic err_r;

   // An address below BASE_ADDR wraps to a huge offset. The explicit
   // compare keeps the fault reason obvious.
   assign fault    = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                     (word_off >= DEPTH_U);
   assign idx      = IDX_W'(word_off);
   assign resp_err = err_r;
`else
   assign fault    = 1'b0;
   assign idx      = IDX_W'(word_off % DEPTH_U);
   assign resp_err = 1'b0;
`endif

   assign resp_rdata = rdata_r;

   // State, response registers and storage
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rdata_r <= '0;
`ifdef DMEM_ERR_CHECK_EN
         err_r   <= 1'b0;
`endif
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (accept) begin
`ifdef DMEM_ERR_CHECK_EN
            err_r <= fault;
`endif
            // The load is captured at accept, so the response stays fixed
            // however long the requester stalls.
            if (req_write || fault) begin
               rdata_r <= '0;
            end else begin
               rdata_r <= mem[idx];
            end
            if (req_write && !fault) begin
               for (int b = 0; b < 4; b++) begin
                  if (req_wstrb[b]) begin
                     mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (LATENCY == 1) begin
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
                  cnt_next   = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_next = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            // Completing a response returns to IDLE. No new request can be
            // taken in this same cycle.
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder. A behavioural memory model (plain
//   word array with mask arithmetic) predicts every response. Directed
//   scenarios cover the documented cases. A randomized phase mixes loads,
//   stores, odd addresses and response back-pressure.
//   Compile with +define+DMEM_ERR_CHECK_EN to exercise the fault checks.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int          DEPTH   = 256;
   localparam int          LAT     = 2;
   localparam logic [31:0] BASE    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int npass  = 0;
   int ntotal = 0;

   logic [31:0] mdl [DEPTH];

   dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
   endtask

   task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [31:0] rd, output logic er);
      logic [31:0] mask;
      int unsigned widx;
      bit          bad;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
`ifdef DMEM_ERR_CHECK_EN
      bad  = (a % 4 != 0) || (a < BASE) || (((a - BASE) / 4) >= DEPTH);
      widx = (a - BASE) / 4;
`else
      bad  = 1'b0;
      widx = ((a - BASE) / 4) % DEPTH;
`endif
      er = bad;
      rd = 32'h0;
      if (!bad) begin
         if (w) mdl[widx] = (mdl[widx] & ~mask) | (d & mask);
         else   rd = mdl[widx];
      end
   endtask

   // ---------------- transaction driver ----------------
   task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int hold,
                       output logic [31:0] rd, output logic er, output int lat,
                       output bit stable, output bit after_ok);
      int n;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = w;
      req_addr   = a;
      req_wdata  = d;
      req_wstrb  = s;
      resp_ready = (hold == 0);
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      // Request fields change after accept; the DUT must ignore them.
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      lat = 1;
      while (!resp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rd = resp_rdata;
      er = resp_err;
      stable = (req_ready === 1'b0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0)
            stable = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      after_ok = (req_ready === 1'b1) && (resp_valid === 1'b0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      ntotal++;
      if ({req_ready, resp_valid, resp_err} !== 3'b100 || resp_rdata !== 32'h0)
         $display("FAIL reset_state: ready/valid/err=%b rdata=%h, required 100 rdata=00000000",
                  {req_ready, resp_valid, resp_err}, resp_rdata);
      else npass++;
   endtask

   task automatic test_store_load();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      bit          st, ok;
      model_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
      xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st, ok);
      ntotal++;
      if (lat != LAT || rd !== erd || er !== eer || !ok)
         $display("FAIL store_0x10: lat=%0d rdata=%h err=%b ok=%0d, required lat=%0d rdata=%h err=%b ok=1",
                  lat, rd, er, ok, LAT, erd, eer);
      else npass++;
      model_access(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
      xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, ok);
      ntotal++;
      if (lat != LAT || rd !== 32'hDEADBEEF || rd !== erd || er !== 1'b0 || !ok)
         $display("FAIL load_0x10: lat=%0d rdata=%h err=%b ok=%0d, required lat=%0d rdata=deadbeef err=0 ok=1",
                  lat, rd, er, ok, LAT);
      else npass++;
   endtask

   task automatic test_strobe();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      bit          st, ok;
      model_access(1'b1, 32'h20, 32'h11223344, 4'hF, erd, eer);
      xact(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, st, ok);
      model_access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, erd, eer);
      xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat, st, ok);
      model_access(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, erd, eer);
      xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat, st, ok);
      ntotal++;
      if (er !== 1'b0 || rd !== 32'h0)
         $display("FAIL wstrb0_store: err=%b rdata=%h, required err=0 rdata=00000000", er, rd);
      else npass++;
      model_access(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
      xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, ok);
      ntotal++;
      if (rd !== 32'h11BB33DD || rd !== erd || er !== 1'b0)
         $display("FAIL strobe_merge: rdata=%h err=%b, required rdata=11bb33dd err=0", rd, er);
      else npass++;
   endtask

   task automatic test_hold();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      bit          st, ok;
      model_access(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
      xact(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat, st, ok);
      ntotal++;
      if (!st || rd !== erd)
         $display("FAIL hold_stable: stable=%0d rdata=%h, required stable=1 rdata=%h", st, rd, erd);
      else npass++;
      ntotal++;
      if (!ok)
         $display("FAIL hold_release: req_ready=%b resp_valid=%b, required 1 0", req_ready, resp_valid);
      else npass++;
   endtask

`ifdef DMEM_ERR_CHECK_EN
   task automatic test_fault();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      bit          st, ok;
      model_access(1'b0, 32'h13, 32'h0, 4'h0, erd, eer);
      xact(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat, st, ok);
      ntotal++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != LAT)
         $display("FAIL misaligned_load: err=%b rdata=%h lat=%0d, required err=1 rdata=00000000 lat=%0d",
                  er, rd, lat, LAT);
      else npass++;
      model_access(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, erd, eer);
      xact(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, st, ok);
      ntotal++;
      if (er !== 1'b1 || lat != LAT)
         $display("FAIL range_store: err=%b lat=%0d, required err=1 lat=%0d", er, lat, LAT);
      else npass++;
      model_access(1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
      xact(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, st, ok);
      ntotal++;
      if (rd !== 32'h0 || rd !== erd || er !== 1'b0)
         $display("FAIL after_fault_load: rdata=%h err=%b, required rdata=00000000 err=0", rd, er);
      else npass++;
   endtask
`else
   task automatic test_wrap();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      bit          st, ok;
      model_access(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, erd, eer);
      xact(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, st, ok);
      ntotal++;
      if (er !== 1'b0 || lat != LAT)
         $display("FAIL wrap_store: err=%b lat=%0d, required err=0 lat=%0d", er, lat, LAT);
      else npass++;
      model_access(1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
      xact(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, st, ok);
      ntotal++;
      if (rd !== 32'hCAFEF00D || rd !== erd || er !== 1'b0)
         $display("FAIL wrap_load: rdata=%h err=%b, required rdata=cafef00d err=0", rd, er);
      else npass++;
   endtask
`endif

   task automatic test_random();
      logic [31:0] a, d, rd, erd;
      logic [3:0]  s;
      logic        w, er, eer;
      int          lat, hold;
      bit          st, ok;
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 9) < 7) a = BASE + 32'($urandom_range(0, 15)) * 4;
         else                          a = $urandom;
         w    = 1'($urandom);
         d    = $urandom;
         s    = 4'($urandom);
         hold = $urandom_range(0, 3);
         model_access(w, a, d, s, erd, eer);
         xact(w, a, d, s, hold, rd, er, lat, st, ok);
         ntotal++;
         if (rd !== erd || er !== eer || lat != LAT || !st || !ok)
            $display("FAIL random_%0d: w=%b a=%h rdata=%h err=%b lat=%0d st=%0d ok=%0d, required rdata=%h err=%b lat=%0d st=1 ok=1",
                     t, w, a, rd, er, lat, st, ok, erd, eer, LAT);
         else npass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat, n;
      bit          st, ok, seen;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 32'h24;
      req_wdata  = 32'h5A5AA5A5;
      req_wstrb  = 4'hF;
      resp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      seen = 1'b0;
      repeat (LAT + 4) begin
         if (resp_valid) seen = 1'b1;
         @(negedge clk);
      end
      resp_ready = 1'b0;
      ntotal++;
      if (seen)
         $display("FAIL reset_mid_valid: resp_valid seen=%0d, required 0", seen);
      else npass++;
      model_access(1'b0, 32'h24, 32'h0, 4'h0, erd, eer);
      xact(1'b0, 32'h24, 32'h0, 4'h0, 0, rd, er, lat, st, ok);
      ntotal++;
      if (rd !== 32'h0 || rd !== erd || er !== 1'b0)
         $display("FAIL reset_mid_load: rdata=%h err=%b, required rdata=00000000 err=0", rd, er);
      else npass++;
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_wstrb  = '0;
      resp_ready = 1'b0;
      model_clear();
      test_reset();
      test_store_load();
      test_strobe();
      test_hold();
`ifdef DMEM_ERR_CHECK_EN
      test_fault();
`else
      test_wrap();
`endif
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
